// File: rtl/fb_read_responder.sv
// Frame-buffer read responder: request FIFO in front of a single-port word array
// with a fixed-latency read pipeline. Define FB_RESP_OOB_EN to add out-of-range detection.
module fb_read_responder #(
  parameter int ADDR_W      = 32,
  parameter int PIXEL_BYTES = 4,
  parameter int DEPTH_LOG2  = 10,
  parameter int QDEPTH      = 4,
  parameter int LATENCY     = 2
) (
  input  logic                     pix_clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        fb_base,
  input  logic                     mem_req,
  input  logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_ready,
  output logic [PIXEL_BYTES*8-1:0] mem_rdata,
  output logic                     mem_rvalid,
  input  logic                     arb_busy,
  input  logic                     wr_en,
  input  logic [DEPTH_LOG2-1:0]    wr_idx,
`ifdef FB_RESP_OOB_EN
  input  logic [PIXEL_BYTES*8-1:0] wr_data,
  input  logic                     err_clr,
  output logic                     oob_err
`else
  input  logic [PIXEL_BYTES*8-1:0] wr_data
`endif
);

  localparam int DW    = PIXEL_BYTES * 8;
  localparam int OFS   = $clog2(PIXEL_BYTES);
  localparam int PW    = $clog2(QDEPTH);
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic                  oob;
    logic [DEPTH_LOG2-1:0] idx;
  } req_t;

  // ---------------- request decode ----------------
  logic [ADDR_W-1:0] off;
  req_t              in_req;

  assign off = mem_addr - fb_base;

  always_comb begin
    in_req.idx = DEPTH_LOG2'(off >> OFS);
    in_req.oob = 1'b0;
`ifdef FB_RESP_OOB_EN
    in_req.oob = (mem_addr < fb_base) || ((off >> (OFS + DEPTH_LOG2)) != '0);
`endif
  end

  // ---------------- request FIFO ----------------
  req_t            q_mem [QDEPTH];
  logic [PW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            push, pop;
  req_t            head;

  assign mem_ready = (cnt < CW'(QDEPTH));
  assign push      = mem_req & mem_ready;
  // host writes own the array port, so they block a pop
  assign pop       = (cnt != '0) & ~arb_busy & ~wr_en;
  assign head      = q_mem[rp];

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (push) q_mem[wp] <= in_req;
  end

  // ---------------- single-port array ----------------
  logic [DW-1:0] ram [WORDS];
  logic [DW-1:0] ram_q;

  always_ff @(posedge pix_clk) begin
    if (wr_en)    ram[wr_idx] <= wr_data;
    else if (pop) ram_q       <= ram[head.idx];
  end

  // ---------------- read pipeline ----------------
  // vld_pipe[0] is aligned with ram_q; vld_pipe[LATENCY] is the response
  logic [LATENCY:0]          vld_pipe, oob_pipe;
  logic [LATENCY:1][DW-1:0]  dat_pipe, stage_in;

  always_comb begin
    stage_in    = '0;
    stage_in[1] = ram_q;
    for (int k = 2; k <= LATENCY; k++) stage_in[k] = dat_pipe[k-1];
    if (oob_pipe[LATENCY-1]) stage_in[LATENCY] = '0;
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      oob_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:0], pop};
      oob_pipe <= {oob_pipe[LATENCY-1:0], head.oob};
      // stages load only with valid data so the output holds between responses
      for (int k = 1; k <= LATENCY; k++)
        if (vld_pipe[k-1]) dat_pipe[k] <= stage_in[k];
    end
  end

  assign mem_rvalid = vld_pipe[LATENCY];
  assign mem_rdata  = dat_pipe[LATENCY];

`ifdef FB_RESP_OOB_EN
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n)                                      oob_err <= 1'b0;
    else if (vld_pipe[LATENCY-1] && oob_pipe[LATENCY-1]) oob_err <= 1'b1;
    else if (err_clr)                                oob_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fb_read_responder.sv
// Scoreboard bench for fb_read_responder: directed scenarios plus a randomized phase
// checked against a word-array model indexed straight from the address rules.
module tb_fb_read_responder;
  localparam int WORDS = 1024;

  logic        pix_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] fb_base = 32'h1000;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        arb_busy = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;
`ifdef FB_RESP_OOB_EN
  logic        err_clr = 1'b0;
  logic        oob_err;
`endif

  fb_read_responder dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .fb_base(fb_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .arb_busy(arb_busy),
    .wr_en(wr_en), .wr_idx(wr_idx),
`ifdef FB_RESP_OOB_EN
    .wr_data(wr_data), .err_clr(err_clr), .oob_err(oob_err)
`else
    .wr_data(wr_data)
`endif
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct { int idx; bit oob; } exp_t;

  exp_t        sb[$];
  int          rv_log[$];
  logic [31:0] shadow [WORDS];
  int          errors = 0, checks = 0, cyc = 0, rv_count = 0, acc_edge = 0;
  logic [31:0] last_data = '0;

  always @(posedge pix_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: word index is the byte offset from fb_base in words, modulo array size
  function automatic exp_t model(input logic [31:0] a);
    exp_t        r;
    logic [31:0] o;
    o     = a - fb_base;
    r.idx = int'((o >> 2) % WORDS);
    r.oob = 1'b0;
`ifdef FB_RESP_OOB_EN
    r.oob = (a < fb_base) || ((o >> 2) >= WORDS);
`endif
    return r;
  endfunction

  function automatic bit pending(input int i);
    foreach (sb[k]) if (sb[k].idx == i) return 1'b1;
    return 1'b0;
  endfunction

  // monitor: compares every response against the oldest expected entry
  always @(negedge pix_clk) begin
    exp_t e;
    if (!rst_n) last_data = '0;
    else if (mem_rvalid) begin
      rv_count++;
      rv_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d expected no response", cyc);
      end else begin
        e = sb.pop_front();
        chk("rdata", mem_rdata, e.oob ? 32'h0 : shadow[e.idx]);
      end
      last_data = mem_rdata;
    end else chk("rdata_hold", mem_rdata, last_data);
  end

  task automatic req(input logic [31:0] a);
    mem_req  = 1'b1;
    mem_addr = a;
    for (int t = 0; t < 60; t++) begin
      @(negedge pix_clk);
      if (mem_ready) begin
        sb.push_back(model(a));
        acc_edge = cyc + 1;
        @(posedge pix_clk); #1;
        mem_req = 1'b0;
        return;
      end
      @(posedge pix_clk); #1;
    end
    chk("req_timeout", 0, 1);
    mem_req = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge pix_clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge pix_clk);
    #1;
  endtask

  initial begin
    int a0, r0, e0;
    logic [31:0] v;

    // reset state
    repeat (3) @(negedge pix_clk);
    chk("rst_ready", mem_ready, 1);
    chk("rst_rvalid", mem_rvalid, 0);
    chk("rst_rdata", mem_rdata, 0);
    @(posedge pix_clk); #1;
    rst_n = 1'b1;

    // preload the whole array through the host port
    for (int i = 0; i < WORDS; i++) begin
      v = (i == 5) ? 32'hA5A5_0005 : $urandom;
      wr_en = 1'b1; wr_idx = 10'(i); wr_data = v; shadow[i] = v;
      @(posedge pix_clk); #1;
    end
    wr_en = 1'b0;

    // single read, latency A+3
    req(32'h1014);
    a0 = acc_edge;
    rv_log.delete();
    drain();
    chk("single_lat", rv_log.size() > 0 ? rv_log[0] - a0 : -1, 3);
    chk("single_data", last_data, 32'hA5A5_0005);

    // back-to-back stream of 8
    rv_log.delete();
    r0 = rv_count;
    req(32'h1000);
    a0 = acc_edge;
    for (int i = 1; i < 8; i++) req(32'h1000 + 32'(4 * i));
    drain();
    chk("stream_count", rv_count - r0, 8);
    chk("stream_first_lat", rv_log.size() == 8 ? rv_log[0] - a0 : -1, 3);
    chk("stream_span", rv_log.size() == 8 ? rv_log[7] - rv_log[0] : -1, 7);

    // full FIFO while the array port is lost
    r0 = rv_count;
    arb_busy = 1'b1;
    for (int i = 0; i < 4; i++) req(32'h1000 + 32'(4 * (20 + i)));
    fork
      req(32'h1000 + 32'(4 * 24));
      begin
        repeat (4) @(negedge pix_clk);
        chk("full_ready", mem_ready, 0);
        chk("full_no_rvalid", rv_count - r0, 0);
        @(posedge pix_clk); #1;
        arb_busy = 1'b0;
      end
    join
    drain();
    chk("full_count", rv_count - r0, 5);

    // write priority delays pops by 3 cycles
    arb_busy = 1'b1;
    req(32'h1000 + 32'(4 * 30));
    req(32'h1000 + 32'(4 * 31));
    rv_log.delete();
    arb_busy = 1'b0;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      v = $urandom;
      wr_en = 1'b1; wr_idx = 10'(100 + k); wr_data = v; shadow[100 + k] = v;
      @(posedge pix_clk); #1;
    end
    wr_en = 1'b0;
    drain();
    chk("wrprio_first", rv_log.size() == 2 ? rv_log[0] - e0 : -1, 5);
    chk("wrprio_second", rv_log.size() == 2 ? rv_log[1] - e0 : -1, 6);

`ifdef FB_RESP_OOB_EN
    err_clr = 1'b1; @(posedge pix_clk); #1; err_clr = 1'b0;
    req(32'h0FFC);
    drain();
    chk("oob_data", last_data, 0);
    chk("oob_err_set", oob_err, 1);
    repeat (3) @(posedge pix_clk); #1;
    chk("oob_err_sticky", oob_err, 1);
    err_clr = 1'b1; @(posedge pix_clk); #1; err_clr = 1'b0;
    chk("oob_err_clr", oob_err, 0);
`endif

    // randomized traffic with arbitration loss, host writes and aliasing addresses
    fb_base = $urandom;
    for (int c = 0; c < 1500; c++) begin
      int i;
      arb_busy = ($urandom_range(0, 3) == 0);
      wr_en = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        i = $urandom_range(0, WORDS - 1);
        if (!pending(i)) begin
          v = $urandom;
          wr_en = 1'b1; wr_idx = 10'(i); wr_data = v; shadow[i] = v;
        end
      end
      mem_req = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) mem_addr = $urandom;
      else mem_addr = fb_base + 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(0, 3));
      @(negedge pix_clk);
      if (mem_req && mem_ready) sb.push_back(model(mem_addr));
      @(posedge pix_clk); #1;
    end
    mem_req = 1'b0; arb_busy = 1'b0; wr_en = 1'b0;
    drain();

    // reset with three requests in flight
    fb_base = 32'h1000;
    r0 = rv_count;
    req(32'h1000);
    req(32'h1004);
    req(32'h1008);
    rst_n = 1'b0;
    sb.delete();
    @(posedge pix_clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge pix_clk); #1;
    chk("rst_mid_no_rvalid", rv_count - r0, 0);
    chk("rst_mid_ready", mem_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
